icache_refill_ctrl: RTL and testbench
=====================================

# icache_refill_ctrl

Miss handler for the fetch-side instruction cache. It sits between fetch, the i-cache and the instruction memory port. On a fetch read miss it stalls fetch and requests the missing word from memory. It then fills the cache through the cache write port and releases the stall once the refilled entry reads back as a hit. It also handles flush, memory error and memory timeout, and keeps a miss counter.

## Interface
- TIMEOUT, default 255: max WAIT cycles without response before fault; legal range 2..2^CNT_W-1
- CNT_W, default 8: width of the timeout counter
- CLK in 1: clock; all state updates on posedge
- RESET in 1: asynchronous, active-low reset
- fetch_valid in 1: fetch presents fetch_pc to cache this cycle
- fetch_pc in 32: PC being read from the cache
- read_hit in 1: cache hit for fetch_pc (combinational from cache)
- flush in 1: redirect; abandon any in-progress miss
- stall out 1: fetch must hold fetch_pc
- mem_req_valid out 1: memory read request
- mem_req_ready in 1: memory accepts request
- mem_req_addr out 32: word-aligned miss address
- mem_resp_valid in 1: response data valid
- mem_resp_data in 32: instruction word
- mem_resp_err in 1: response is an error (qualified by mem_resp_valid)
- write_request out 1: cache fill strobe
- write_address out 32: fill PC
- write_data out 32: fill instruction
- fetch_fault out 1: refill failed, held until fault_ack
- fault_addr out 32: miss address that faulted
- fault_ack in 1: fault consumed
- miss_count out 32: number of misses started, wraps at 2^32

## Operation
- States: IDLE, REQ, WAIT, FILL, REPLAY, ERR. Reset: IDLE, miss_addr=0, data=0, drop=0, wait_cnt=0, miss_count=0.
- All outputs are 0 at reset; stall=0 after reset.
- stall = (state!=IDLE && state!=ERR) || (state==IDLE && fetch_valid && !read_hit && !flush) || state==ERR.
- IDLE:
  - On fetch_valid && !read_hit && !flush: latch miss_addr={fetch_pc[31:2],2'b00}, miss_count+=1, go to REQ.
  - flush has priority over a same-cycle miss.
- REQ:
  - mem_req_valid=1, mem_req_addr=miss_addr.
  - flush && !mem_req_ready -> IDLE.
  - mem_req_ready -> WAIT with wait_cnt=0 and drop=flush.
  - The request is never withdrawn on the same cycle it is accepted.
- WAIT:
  - flush sets drop=1.
  - On mem_resp_valid with drop (or same-cycle flush) -> IDLE, no fill.
  - On mem_resp_valid with mem_resp_err -> ERR.
  - On mem_resp_valid otherwise: latch data -> FILL.
  - With no response: wait_cnt+=1. If wait_cnt==TIMEOUT-1 -> ERR, or -> IDLE if drop.
- FILL:
  - write_request=1 for exactly one cycle, write_address=miss_addr, write_data=latched data -> REPLAY.
  - flush here still completes the fill, then goes to IDLE (no REPLAY).
- REPLAY: one cycle so the cache read of the written entry is valid -> IDLE.
- ERR:
  - fetch_fault=1, fault_addr=miss_addr.
  - fault_ack or flush -> IDLE, clearing fetch_fault next cycle.
- Only one outstanding memory request ever exists.
- mem_resp_valid outside WAIT is ignored.
- Asserting reset mid-operation returns to IDLE immediately. Any response still in flight after reset is ignored, because it arrives outside WAIT.

## Timing
- write_request, write_address, write_data, mem_req_* and fetch_fault are registered-state decodes with no input-to-output path.
- stall has a combinational path from fetch_valid/read_hit/flush in IDLE.
- Minimum miss sequence (ready and response each immediate):
  - cycle 0: IDLE miss, stall=1
  - cycle 1: REQ accepted
  - cycle 2: WAIT, response arrives
  - cycle 3: FILL, write_request=1
  - cycle 4: REPLAY
  - cycle 5: IDLE, read_hit=1, stall=0
- This gives a 5-cycle penalty.
- Each extra REQ or WAIT cycle adds one cycle.
- Timeout fires on WAIT cycle TIMEOUT with no response; ERR is visible the next cycle.

## Test plan
- Reset, then fetch_pc=0x0000_1004 miss, ready and response immediate with data 0xDEAD_BEEF:
  - write_request on cycle 3 with write_address=0x0000_1004, write_data=0xDEAD_BEEF.
  - stall deasserts on cycle 5; miss_count=1.
- Hit path: fetch_valid=1, read_hit=1 for 10 cycles -> stall=0, mem_req_valid=0, miss_count unchanged.
- Backpressure and latency: mem_req_ready low for 3 cycles, then response 4 cycles after acceptance -> mem_req_addr stable throughout, exactly one accepted request, exactly one write_request pulse.
- Flush during WAIT, then response arrives -> no write_request, state returns to IDLE, and a new miss at 0x2000 issues its request afterwards.
- Error response, and separately TIMEOUT=4 with no response:
  - fetch_fault=1 with fault_addr=miss_addr, stall held.
  - fault_ack -> fetch_fault=0 next cycle; a late response is ignored.
- Reset asserted during WAIT -> all outputs 0 asynchronously; miss_count=0 after release.

Source files
------------

// File: rtl/icache_refill_ctrl.sv
// icache_refill_ctrl: fetch-side i-cache miss handler (request, fill, replay, fault)
module icache_refill_ctrl #(
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned CNT_W   = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        fetch_valid_i,
    input  logic [31:0] fetch_pc_i,
    input  logic        read_hit_i,
    input  logic        flush_i,
    output logic        stall_o,
    output logic        mem_req_valid_o,
    input  logic        mem_req_ready_i,
    output logic [31:0] mem_req_addr_o,
    input  logic        mem_resp_valid_i,
    input  logic [31:0] mem_resp_data_i,
    input  logic        mem_resp_err_i,
    output logic        write_request_o,
    output logic [31:0] write_address_o,
    output logic [31:0] write_data_o,
    output logic        fetch_fault_o,
    output logic [31:0] fault_addr_o,
    input  logic        fault_ack_i,
    output logic [31:0] miss_count_o
);
    typedef enum logic [2:0] {IDLE, REQ, WAIT, FILL, REPLAY, ERR} state_e;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);
    state_e            state_q, state_d;
    logic [31:0]       miss_addr_q, miss_addr_d, data_q, data_d, miss_count_q, miss_count_d;
    logic              drop_q, drop_d;
    logic [CNT_W-1:0]  wait_cnt_q, wait_cnt_d;
    logic              miss;
    assign miss = fetch_valid_i && !read_hit_i && !flush_i;
    always_comb begin
        state_d      = state_q;
        miss_addr_d  = miss_addr_q;
        data_d       = data_q;
        miss_count_d = miss_count_q;
        drop_d       = drop_q;
        wait_cnt_d   = wait_cnt_q;
        case (state_q)
            IDLE: if (miss) begin
                miss_addr_d  = fetch_pc_i & ~32'h3;
                miss_count_d = miss_count_q + 32'd1;
                state_d      = REQ;
            end
            REQ: if (mem_req_ready_i) begin
                state_d    = WAIT;
                wait_cnt_d = '0;
                drop_d     = flush_i;
            end else if (flush_i) begin
                state_d = IDLE;
            end
            WAIT: begin
                drop_d = drop_q || flush_i;
                // a flushed miss must never fill, even if the response carries an error
                if (mem_resp_valid_i) begin
                    data_d  = mem_resp_data_i;
                    state_d = drop_d ? IDLE : mem_resp_err_i ? ERR : FILL;
                end else if (wait_cnt_q == LAST) begin
                    state_d = drop_d ? IDLE : ERR;
                end else begin
                    wait_cnt_d = wait_cnt_q + CNT_W'(1);
                end
            end
            FILL:    state_d = flush_i ? IDLE : REPLAY;
            REPLAY:  state_d = IDLE;
            ERR:     state_d = (fault_ack_i || flush_i) ? IDLE : ERR;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            miss_addr_q  <= '0;
            data_q       <= '0;
            miss_count_q <= '0;
            drop_q       <= 1'b0;
            wait_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            miss_addr_q  <= miss_addr_d;
            data_q       <= data_d;
            miss_count_q <= miss_count_d;
            drop_q       <= drop_d;
            wait_cnt_q   <= wait_cnt_d;
        end
    end
    assign stall_o         = (state_q != IDLE) || miss;
    assign mem_req_valid_o = state_q == REQ;
    assign mem_req_addr_o  = miss_addr_q;
    assign write_request_o = state_q == FILL;
    assign write_address_o = miss_addr_q;
    assign write_data_o    = data_q;
    assign fetch_fault_o   = state_q == ERR;
    assign fault_addr_o    = miss_addr_q;
    assign miss_count_o    = miss_count_q;
endmodule

// File: tb/tb_icache_refill_ctrl.sv
// tb_icache_refill_ctrl: directed bench with a fill scoreboard; second instance uses TIMEOUT=4
module tb_icache_refill_ctrl;
    typedef struct packed {logic v; logic [31:0] a; logic [31:0] d;} fill_t;
    logic clk, rst_n, fetch_valid, read_hit, flush, mem_req_ready, mem_resp_valid, mem_resp_err, fault_ack;
    logic [31:0] fetch_pc, mem_resp_data;
    logic stall, mem_req_valid, write_request, fetch_fault;
    logic [31:0] mem_req_addr, write_address, write_data, fault_addr, miss_count;
    logic t_stall, t_mem_req_valid, t_write_request, t_fetch_fault;
    logic [31:0] t_mem_req_addr, t_write_address, t_write_data, t_fault_addr, t_miss_count;
    fill_t q[$];
    int vec = 0, errs = 0, acc = 0, wr_pulses = 0, a0, w0;

    icache_refill_ctrl dut (
        .clk(clk), .rst_n(rst_n), .fetch_valid_i(fetch_valid), .fetch_pc_i(fetch_pc),
        .read_hit_i(read_hit), .flush_i(flush), .stall_o(stall), .mem_req_valid_o(mem_req_valid),
        .mem_req_ready_i(mem_req_ready), .mem_req_addr_o(mem_req_addr), .mem_resp_valid_i(mem_resp_valid),
        .mem_resp_data_i(mem_resp_data), .mem_resp_err_i(mem_resp_err), .write_request_o(write_request),
        .write_address_o(write_address), .write_data_o(write_data), .fetch_fault_o(fetch_fault),
        .fault_addr_o(fault_addr), .fault_ack_i(fault_ack), .miss_count_o(miss_count)
    );
    icache_refill_ctrl #(.TIMEOUT(4)) dut_to (
        .clk(clk), .rst_n(rst_n), .fetch_valid_i(fetch_valid), .fetch_pc_i(fetch_pc),
        .read_hit_i(read_hit), .flush_i(flush), .stall_o(t_stall), .mem_req_valid_o(t_mem_req_valid),
        .mem_req_ready_i(mem_req_ready), .mem_req_addr_o(t_mem_req_addr), .mem_resp_valid_i(mem_resp_valid),
        .mem_resp_data_i(mem_resp_data), .mem_resp_err_i(mem_resp_err), .write_request_o(t_write_request),
        .write_address_o(t_write_address), .write_data_o(t_write_data), .fetch_fault_o(t_fetch_fault),
        .fault_addr_o(t_fault_addr), .fault_ack_i(fault_ack), .miss_count_o(t_miss_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        vec++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // advance one clock; every fill pulse on the main instance is matched against the scoreboard
    task automatic cyc();
        fill_t e;
        acc += int'(mem_req_valid && mem_req_ready);
        @(posedge clk);
        #1;
        if (write_request) begin
            e = '0;
            if (q.size() > 0) e = q.pop_front();
            wr_pulses++;
            chk("fill", {1'b1, write_address, write_data}, e);
        end
    endtask

    initial begin
        rst_n = 0; fetch_valid = 0; fetch_pc = 0; read_hit = 0; flush = 0; mem_req_ready = 0;
        mem_resp_valid = 0; mem_resp_data = 0; mem_resp_err = 0; fault_ack = 0;
        #12;
        chk("rst_outs", {stall, mem_req_valid, write_request, fetch_fault, mem_req_addr, fault_addr}, '0);
        chk("rst_cnt", miss_count, 0);
        @(posedge clk); #1; rst_n = 1;
        cyc();
        // minimum-latency miss
        fetch_valid = 1; fetch_pc = 32'h0000_1004; read_hit = 0; mem_req_ready = 1;
        q.push_back('{1'b1, 32'h0000_1004, 32'hDEAD_BEEF});
        #1 chk("c0_stall", stall, 1);
        cyc();
        chk("c1_req", {mem_req_valid, mem_req_addr}, {1'b1, 32'h0000_1004});
        cyc();
        mem_req_ready = 0; mem_resp_valid = 1; mem_resp_data = 32'hDEAD_BEEF;
        cyc();
        chk("c3_wr", write_request, 1);
        mem_resp_valid = 0;
        cyc();
        chk("c4_replay_stall", {stall, write_request}, 2'b10);
        read_hit = 1;
        cyc();
        chk("c5_stall", stall, 0);
        chk("c5_cnt", miss_count, 1);
        // hit path
        for (int i = 0; i < 10; i++) begin
            fetch_pc = 32'h100 + 32'(4 * i);
            #1 chk("hit", {stall, mem_req_valid}, 2'b00);
            cyc();
        end
        chk("hit_cnt", miss_count, 1);
        // backpressure and response latency
        a0 = acc; w0 = wr_pulses;
        fetch_pc = 32'h0000_3008; read_hit = 0; mem_req_ready = 0;
        q.push_back('{1'b1, 32'h0000_3008, 32'h1234_5678});
        cyc();
        for (int i = 0; i < 3; i++) begin
            chk("bp_req", {mem_req_valid, mem_req_addr}, {1'b1, 32'h0000_3008});
            cyc();
        end
        mem_req_ready = 1;
        chk("bp_req4", {mem_req_valid, mem_req_addr}, {1'b1, 32'h0000_3008});
        cyc();
        for (int i = 0; i < 4; i++) begin
            if (i == 3) begin mem_resp_valid = 1; mem_resp_data = 32'h1234_5678; end
            chk("bp_wait", {mem_req_valid, write_request, stall, mem_req_addr}, {3'b001, 32'h0000_3008});
            cyc();
        end
        mem_resp_valid = 0; mem_req_ready = 0; read_hit = 1;
        cyc();
        cyc();
        chk("bp_stall", stall, 0);
        chk("bp_one_req", acc - a0, 1);
        chk("bp_one_wr", wr_pulses - w0, 1);
        chk("bp_cnt", miss_count, 2);
        // flush wins over a same-cycle miss in IDLE
        fetch_pc = 32'h0000_9000; read_hit = 0; flush = 1;
        #1 chk("flush_idle_stall", stall, 0);
        cyc();
        flush = 0; fetch_valid = 0;
        chk("flush_idle", {mem_req_valid, miss_count}, {1'b0, 32'd2});
        // flush during WAIT, late response dropped
        fetch_valid = 1; fetch_pc = 32'h0000_5000; mem_req_ready = 1;
        cyc();
        fetch_valid = 0;
        cyc();
        mem_req_ready = 0; flush = 1;
        cyc();
        flush = 0;
        chk("fw_wait_stall", stall, 1);
        mem_resp_valid = 1; mem_resp_data = 32'h5555_5555;
        cyc();
        mem_resp_valid = 0;
        chk("fw_idle", {stall, write_request, mem_req_valid}, 3'b000);
        cyc();
        fetch_valid = 1; fetch_pc = 32'h0000_2000;
        cyc();
        chk("fw_newreq", {mem_req_valid, mem_req_addr}, {1'b1, 32'h0000_2000});
        mem_req_ready = 1;
        q.push_back('{1'b1, 32'h0000_2000, 32'hCAFE_F00D});
        cyc();
        mem_req_ready = 0; mem_resp_valid = 1; mem_resp_data = 32'hCAFE_F00D;
        cyc();
        mem_resp_valid = 0; read_hit = 1;
        cyc();
        cyc();
        chk("fw_done", {stall, miss_count}, {1'b0, 32'd4});
        // error response
        fetch_pc = 32'h0000_6004; read_hit = 0; mem_req_ready = 1;
        cyc();
        cyc();
        mem_req_ready = 0; mem_resp_valid = 1; mem_resp_err = 1; mem_resp_data = 32'hBAD0_BAD0;
        cyc();
        mem_resp_valid = 0; mem_resp_err = 0;
        chk("err_fault", {fetch_fault, stall, fault_addr}, {2'b11, 32'h0000_6004});
        cyc();
        chk("err_held", {fetch_fault, stall}, 2'b11);
        fetch_valid = 0; fault_ack = 1;
        cyc();
        fault_ack = 0;
        chk("err_ack", {fetch_fault, stall}, 2'b00);
        mem_resp_valid = 1; mem_resp_data = 32'hBAD1_BAD1;
        cyc();
        mem_resp_valid = 0;
        chk("err_late", {fetch_fault, stall, mem_req_valid, write_request, miss_count}, {4'b0000, 32'd5});
        // reset during WAIT
        fetch_valid = 1; fetch_pc = 32'h0000_7000; read_hit = 0; mem_req_ready = 1;
        cyc();
        fetch_valid = 0;
        cyc();
        mem_req_ready = 0;
        cyc();
        chk("rw_wait", stall, 1);
        #3 rst_n = 0;
        #1 chk("rw_async", {stall, mem_req_valid, write_request, fetch_fault, miss_count}, '0);
        @(posedge clk); #1 rst_n = 1;
        chk("rw_cnt", miss_count, 0);
        mem_resp_valid = 1; mem_resp_data = 32'h7777_7777;
        cyc();
        mem_resp_valid = 0;
        cyc();
        chk("rw_late", {stall, write_request, miss_count}, '0);
        // timeout on the TIMEOUT=4 instance
        fetch_valid = 1; fetch_pc = 32'h0000_8008; mem_req_ready = 1;
        cyc();
        chk("to_req", {t_mem_req_valid, t_mem_req_addr}, {1'b1, 32'h0000_8008});
        cyc();
        mem_req_ready = 0;
        for (int i = 0; i < 4; i++) begin
            chk("to_wait", {t_fetch_fault, t_stall}, 2'b01);
            cyc();
        end
        chk("to_fault", {t_fetch_fault, t_stall, t_fault_addr}, {2'b11, 32'h0000_8008});
        chk("to_main_waits", {fetch_fault, stall}, 2'b01);
        fetch_valid = 0; fault_ack = 1;
        cyc();
        fault_ack = 0;
        chk("to_ack", {t_fetch_fault, t_stall}, 2'b00);
        q.push_back('{1'b1, 32'h0000_8008, 32'h0000_F00D});
        mem_resp_valid = 1; mem_resp_data = 32'h0000_F00D;
        cyc();
        mem_resp_valid = 0;
        chk("to_late", {t_write_request, t_stall, t_miss_count}, {2'b00, 32'd1});
        cyc();
        cyc();
        chk("sb_empty", q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end
endmodule
